gradient_frame_ctrl: RTL and testbench

Frame sequencer and flow controller for the gradient magnitude/angle pipeline. Accepts Sobel x/y pixel pairs from upstream, feeds the non-stallable 17-stage gradient datapath, and generates valid/sof/eof tags aligned with its outputs. Throttles input with a credit counter sized to the downstream FIFO. Loads the magnitude threshold only between frames.

---
 rtl/grad_ctrl_pkg.sv | 14 +
 rtl/grad_tag_delay.sv | 34 +++
 rtl/gradient_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_gradient_frame_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_ctrl_pkg.sv
// Shared types for the gradient frame controller: FSM states, output tag and nominal datapath latency.
package grad_ctrl_pkg;

    localparam int unsigned GRAD_LATENCY = 17;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} grad_state_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
    } grad_tag_t;

endpackage

// File: rtl/grad_tag_delay.sv
// Shift register of frame tags that tracks pixels through the fixed-latency gradient datapath.
module grad_tag_delay
    import grad_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = GRAD_LATENCY + 1
) (
    input  logic      clk,
    input  logic      rst,
    input  grad_tag_t tag_in,
    output grad_tag_t tag_out
);

    grad_tag_t stage_q [DEPTH];
    grad_tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Clear drops every in-flight tag so nothing emerges after a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/gradient_frame_ctrl.sv
// Frame sequencer and credit-based flow control for the gradient datapath.
// Define GRAD_CTRL_STATS_EN to expose frame_cnt, err_sof and err_credit.
module gradient_frame_ctrl
    import grad_ctrl_pkg::*;
#(
    parameter int unsigned DWIDTH    = 10,
    parameter int unsigned MAG_WIDTH = 13,
    parameter int unsigned LATENCY   = GRAD_LATENCY,
    parameter int unsigned CREDITS   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MAG_WIDTH-1:0]   cfg_threshold,
    input  logic                   cfg_load,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   s_sof,
    input  logic                   s_eof,
    input  logic signed [DWIDTH+2:0] s_x,
    input  logic signed [DWIDTH+2:0] s_y,
    output logic signed [DWIDTH+2:0] g_x,
    output logic signed [DWIDTH+2:0] g_y,
    output logic                   g_mask,
    output logic [MAG_WIDTH-1:0]   g_threshold,
    input  logic                   credit_ret,
    output logic                   m_valid,
    output logic                   m_sof,
    output logic                   m_eof,
    output logic                   busy,
    output logic                   frame_done
`ifdef GRAD_CTRL_STATS_EN
    ,
    output logic [15:0]            frame_cnt,
    output logic                   err_sof,
    output logic                   err_credit
`endif
);

    localparam int unsigned XW  = DWIDTH + 3;
    localparam int unsigned CW  = $clog2(CREDITS + 1);
    localparam int unsigned DCW = $clog2(LATENCY + 1);

    grad_state_t             state_q, state_d;
    logic [CW-1:0]           credit_q, credit_d;
    logic [DCW-1:0]          drain_cnt_q, drain_cnt_d;
    logic [MAG_WIDTH-1:0]    pending_q, pending_d;
    logic [MAG_WIDTH-1:0]    thr_q, thr_d;
    logic signed [XW-1:0]    gx_q, gx_d, gy_q, gy_d;
    logic                    mask_q, mask_d;
    logic                    done_q, done_d;
    logic                    accept, take, ret_ok, credit_full;
    grad_tag_t               tag_in, tag_out;

    // Pixels accepted in IDLE without sof are swallowed: no mask, no tag, no credit.
    always_comb begin
        credit_full = (credit_q == CW'(CREDITS));
        s_ready     = (state_q != DRAIN) && (credit_q != '0);
        accept      = s_valid & s_ready;
        take        = accept & ((state_q != IDLE) | s_sof);
        ret_ok      = credit_ret & (~credit_full | take);

        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        credit_d    = credit_q;
        pending_d   = cfg_load ? cfg_threshold : pending_q;
        thr_d       = thr_q;
        gx_d        = take ? s_x : '0;
        gy_d        = take ? s_y : '0;
        mask_d      = take;
        tag_in      = '{valid: take, sof: take & s_sof, eof: take & s_eof};

        case ({take, ret_ok})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01:   credit_d = credit_q + CW'(1);
            default: credit_d = credit_q;
        endcase

        case (state_q)
            IDLE: begin
                if (take) begin
                    thr_d = pending_q;
                    if (s_eof) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DCW'(LATENCY);
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (take && s_eof) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DCW'(LATENCY);
                end
            end
            DRAIN: begin
                // The eof tag reaches the output on the cycle the count hits zero.
                done_d = (drain_cnt_q == DCW'(1));
                if (drain_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            credit_q    <= CW'(CREDITS);
            drain_cnt_q <= '0;
            pending_q   <= '0;
            thr_q       <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            mask_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            drain_cnt_q <= drain_cnt_d;
            pending_q   <= pending_d;
            thr_q       <= thr_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            mask_q      <= mask_d;
            done_q      <= done_d;
        end
    end

    grad_tag_delay #(
        .DEPTH (LATENCY + 1)
    ) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign g_x         = gx_q;
    assign g_y         = gy_q;
    assign g_mask      = mask_q;
    assign g_threshold = thr_q;
    assign m_valid     = tag_out.valid;
    assign m_sof       = tag_out.sof;
    assign m_eof       = tag_out.eof;
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;

`ifdef GRAD_CTRL_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        err_sof_q, err_sof_d;
    logic        err_credit_q, err_credit_d;

    always_comb begin
        frame_cnt_d  = frame_cnt_q + 16'(done_q);
        err_sof_d    = err_sof_q | (accept & (((state_q == IDLE) & ~s_sof) |
                                              ((state_q == RUN) & s_sof)));
        err_credit_d = err_credit_q | (credit_ret & credit_full & ~take);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q  <= '0;
            err_sof_q    <= 1'b0;
            err_credit_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            err_sof_q    <= err_sof_d;
            err_credit_q <= err_credit_d;
        end
    end

    assign frame_cnt  = frame_cnt_q;
    assign err_sof    = err_sof_q;
    assign err_credit = err_credit_q;
`endif

endmodule

// File: tb/tb_gradient_frame_ctrl.sv
// Bench for gradient_frame_ctrl: vector table, directed frame sequences and random traffic against a cycle-scheduled model.
module tb_gradient_frame_ctrl;

    localparam int          CRED = 4;
    localparam int          LAT  = 17;
    localparam int unsigned XW   = 13;
    localparam int unsigned MW   = 13;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [MW-1:0]        cfg_threshold;
    logic                 cfg_load;
    logic                 s_valid, s_ready, s_sof, s_eof;
    logic signed [XW-1:0] s_x, s_y, g_x, g_y;
    logic                 g_mask;
    logic [MW-1:0]        g_threshold;
    logic                 credit_ret;
    logic                 m_valid, m_sof, m_eof, busy, frame_done;
`ifdef GRAD_CTRL_STATS_EN
    logic [15:0]          frame_cnt;
    logic                 err_sof, err_credit;
`endif

    always #5 clk = ~clk;

    gradient_frame_ctrl #(
        .DWIDTH    (10),
        .MAG_WIDTH (13),
        .LATENCY   (17),
        .CREDITS   (CRED)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_threshold (cfg_threshold),
        .cfg_load      (cfg_load),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_sof         (s_sof),
        .s_eof         (s_eof),
        .s_x           (s_x),
        .s_y           (s_y),
        .g_x           (g_x),
        .g_y           (g_y),
        .g_mask        (g_mask),
        .g_threshold   (g_threshold),
        .credit_ret    (credit_ret),
        .m_valid       (m_valid),
        .m_sof         (m_sof),
        .m_eof         (m_eof),
        .busy          (busy),
        .frame_done    (frame_done)
`ifdef GRAD_CTRL_STATS_EN
        ,
        .frame_cnt     (frame_cnt),
        .err_sof       (err_sof),
        .err_credit    (err_credit)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Model: output tags are scheduled LAT+1 cycles ahead in a ring indexed by absolute cycle.
    int                   cyc = 0;
    int                   m_state;          // 0 idle, 1 in frame, 2 draining
    int                   m_credit, m_drain_end, e_fcnt;
    logic [MW-1:0]        m_pending, m_thr;
    logic [2:0]           m_sched [256];    // {valid, sof, eof}
    logic signed [XW-1:0] e_gx, e_gy;
    logic                 e_mask, e_err_sof, e_err_cred;
    logic                 seen_ready;

    typedef struct {
        logic          v, sof, eof, cr, cl;
        logic [MW-1:0] th;
        logic          exp_ready, exp_mask, exp_busy;
        logic [XW-1:0] exp_gx;
    } vec_t;

    vec_t vt [11];

    function automatic vec_t mkv(input logic v, sof, eof, cr, cl, input int th,
                                 input logic rdy, msk, bsy, input int gx);
        vec_t r;
        r.v = v; r.sof = sof; r.eof = eof; r.cr = cr; r.cl = cl; r.th = MW'(th);
        r.exp_ready = rdy; r.exp_mask = msk; r.exp_busy = bsy; r.exp_gx = XW'(gx);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic [2:0] t;
        t = m_sched[cyc % 256];
        chk("g_x", g_x, e_gx);
        chk("g_y", g_y, e_gy);
        chk("g_mask", g_mask, e_mask);
        chk("g_threshold", g_threshold, m_thr);
        chk("m_valid", m_valid, t[2]);
        chk("m_sof", m_sof, t[1]);
        chk("m_eof", m_eof, t[0]);
        chk("frame_done", frame_done, t[0]);
        chk("busy", busy, m_state != 0);
`ifdef GRAD_CTRL_STATS_EN
        chk("frame_cnt", frame_cnt, e_fcnt);
        chk("err_sof", err_sof, e_err_sof);
        chk("err_credit", err_credit, e_err_cred);
`endif
    endtask

    task automatic model_reset();
        m_state = 0; m_credit = CRED; m_drain_end = 0; e_fcnt = 0;
        m_pending = '0; m_thr = '0;
        e_gx = '0; e_gy = '0; e_mask = 1'b0; e_err_sof = 1'b0; e_err_cred = 1'b0;
        foreach (m_sched[i]) m_sched[i] = 3'b000;
    endtask

    task automatic idle_inputs();
        s_valid = 0; s_sof = 0; s_eof = 0; s_x = '0; s_y = '0;
        credit_ret = 0; cfg_load = 0; cfg_threshold = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        model_reset();
        check_outputs();
    endtask

    // One clock: drive, check s_ready, advance model, then check registered outputs.
    task automatic tick(input logic v, sof, eof, input logic [XW-1:0] x, y,
                        input logic cr, cl, input logic [MW-1:0] th);
        logic ready, acc, take;
        s_valid = v; s_sof = sof; s_eof = eof; s_x = x; s_y = y;
        credit_ret = cr; cfg_load = cl; cfg_threshold = th;
        #2;
        ready      = (m_state != 2) && (m_credit > 0);
        seen_ready = s_ready;
        chk("s_ready", s_ready, ready);
        acc  = v & ready;
        take = acc & ((m_state != 0) | sof);
        e_gx = take ? x : '0;
        e_gy = take ? y : '0;
        e_mask = take;
        if (m_sched[cyc % 256][0]) e_fcnt = (e_fcnt + 1) & 16'hffff;
        m_sched[cyc % 256] = 3'b000;
        m_sched[(cyc + LAT + 1) % 256] = {take, take & sof, take & eof};
        if (m_state == 0 && take) m_thr = m_pending;
        if (cl) m_pending = th;
        if (acc && ((m_state == 0 && !sof) || (m_state == 1 && sof))) e_err_sof = 1'b1;
        if (cr && m_credit == CRED && !take) e_err_cred = 1'b1;
        else m_credit = m_credit - int'(take) + int'(cr);
        case (m_state)
            0: if (take) begin
                   if (eof) begin m_state = 2; m_drain_end = cyc + LAT + 1; end
                   else m_state = 1;
               end
            1: if (take && eof) begin m_state = 2; m_drain_end = cyc + LAT + 1; end
            default: if (cyc == m_drain_end) m_state = 0;
        endcase
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle_tick(input logic cr);
        tick(1'b0, 1'b0, 1'b0, '0, '0, cr, 1'b0, '0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();

        //         v  sof eof cr cl th   rdy msk bsy gx
        vt[0]  = mkv(1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
        vt[1]  = mkv(1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
        vt[2]  = mkv(1, 0, 0, 0, 0, 0,   1, 0, 0, 0);
        vt[3]  = mkv(1, 1, 0, 0, 1, 100, 1, 1, 1, 4);
        vt[4]  = mkv(1, 0, 0, 0, 0, 0,   1, 1, 1, 5);
        vt[5]  = mkv(1, 0, 0, 0, 0, 0,   1, 1, 1, 6);
        vt[6]  = mkv(1, 0, 0, 0, 0, 0,   1, 1, 1, 7);
        vt[7]  = mkv(1, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        vt[8]  = mkv(1, 0, 0, 1, 0, 0,   0, 0, 1, 0);
        vt[9]  = mkv(1, 0, 1, 0, 0, 0,   1, 1, 1, 10);
        vt[10] = mkv(1, 0, 0, 0, 0, 0,   0, 0, 1, 0);

        do_reset();
        chk("rst_ready", s_ready, 1'b1);

        // Dropped non-sof pixels, credit exhaustion, one returned credit, threshold held at old value.
        for (int i = 0; i < 11; i++) begin
            tick(vt[i].v, vt[i].sof, vt[i].eof, XW'(i + 1), XW'(i + 101),
                 vt[i].cr, vt[i].cl, vt[i].th);
            chk("vec_ready", seen_ready, vt[i].exp_ready);
            chk("vec_mask", g_mask, vt[i].exp_mask);
            chk("vec_gx", g_x, vt[i].exp_gx);
            chk("vec_busy", busy, vt[i].exp_busy);
            chk("vec_thr", g_threshold, 0);
        end
`ifdef GRAD_CTRL_STATS_EN
        chk("vec_err_sof", err_sof, 1'b1);
`endif
        for (int k = 0; k < 20; k++) idle_tick(k < 4);
        chk("drain_idle", busy, 1'b0);
        tick(1'b1, 1'b1, 1'b0, XW'(3), XW'(4), 1'b0, 1'b0, '0);
        chk("frame2_thr", g_threshold, 100);
        tick(1'b1, 1'b0, 1'b1, XW'(5), XW'(6), 1'b0, 1'b0, '0);
        for (int k = 0; k < 22; k++) idle_tick(1'b1);

        // Four-pixel frame with credit_ret tied high; cycle k+1 is observed after tick k.
        do_reset();
        for (int k = 0; k < 25; k++) begin
            if (k < 4) tick(1'b1, k == 0, k == 3, XW'(k + 7), XW'(-(k + 7)), 1'b1, 1'b0, '0);
            else       idle_tick(1'b1);
            chk("A_mask", g_mask, k <= 3);
            chk("A_mvalid", m_valid, (k + 1 >= 18) && (k + 1 <= 21));
            chk("A_msof", m_sof, k + 1 == 18);
            chk("A_meof", m_eof, k + 1 == 21);
            chk("A_done", frame_done, k + 1 == 21);
            chk("A_busy", busy, k + 1 <= 21);
        end

        // Single-pixel frame goes straight to drain.
        do_reset();
        for (int k = 0; k < 22; k++) begin
            if (k == 0) tick(1'b1, 1'b1, 1'b1, XW'(9), XW'(9), 1'b0, 1'b0, '0);
            else        idle_tick(k < 2);
            chk("D_msof", m_sof, k + 1 == 18);
            chk("D_meof", m_eof, k + 1 == 18);
            chk("D_done", frame_done, k + 1 == 18);
            chk("D_busy", busy, k + 1 <= 18);
        end

        // Reset five cycles after the sof accept discards the frame.
        do_reset();
        for (int k = 0; k < 5; k++) tick(1'b1, k == 0, 1'b0, XW'(k), XW'(k), 1'b0, 1'b0, '0);
        do_reset();
        for (int k = 0; k < 25; k++) begin
            idle_tick(1'b0);
            chk("C_mvalid", m_valid, 1'b0);
            chk("C_ready", seen_ready, 1'b1);
        end
        for (int k = 0; k < 4; k++) tick(1'b1, k == 0, k == 3, XW'(k), XW'(k), 1'b0, 1'b0, '0);
        chk("C_credit_full", seen_ready, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 14) == 0, XW'($urandom), XW'($urandom),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0, MW'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
